// File: rtl/elastic_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipeline_pkg
// Description : Shared constants, per-stage valid-bit struct and helper
//               functions for the elastic valid/stall pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package elastic_pipeline_pkg;

    localparam int c_DEF_WIDTH = 32;
    localparam int c_DEF_DEPTH = 4;

    // Valid bits of one skid stage: main register and skid register.
    typedef struct packed {
        logic vm;
        logic vs;
    } skid_valid_t;

    // Number of items held by one stage (0..2).
    function automatic logic [1:0] occ_of(input skid_valid_t s);
        return {1'b0, s.vm} + {1'b0, s.vs};
    endfunction

    // Width needed to count 0..2*depth items.
    function automatic int count_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage : elastic_pipeline_pkg
`default_nettype wire

// File: rtl/elastic_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipeline_if
// Description : Valid/stall handshake bundle. The master drives item valid
//               and payload, the slave answers with stall.
// Revision    : 1.0 - initial release
// ============================================================================
interface elastic_pipeline_if #(
    parameter int WIDTH = 32
);
    logic             v;
    logic [WIDTH-1:0] data;
    logic             stall;

    modport master (output v, output data, input  stall);
    modport slave  (input  v, input  data, output stall);
endinterface : elastic_pipeline_if
`default_nettype wire

// File: rtl/elastic_pipeline_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : skid_stage
// Description : Two-entry skid buffer. The main register drives the output,
//               the skid register catches an input while the output is
//               blocked. stall_o comes straight from the skid valid flop.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_stage
    import elastic_pipeline_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             flush_i,
    input  wire logic             v_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic                  stall_o,
    output logic                  v_o,
    output logic [WIDTH-1:0]      data_o,
    input  wire logic             stall_i,
    output logic [1:0]            occ_o
);

    skid_valid_t      r_v;
    logic [WIDTH-1:0] r_dm;
    logic [WIDTH-1:0] r_ds;
    logic             w_take;
    logic             w_out_ok;

    // An input can only be taken while the skid slot is free; the main slot
    // can accept a new item when it is empty or being drained downstream.
    assign w_take   = v_i & ~r_v.vs;
    assign w_out_ok = ~r_v.vm | ~stall_i;

    // Main/skid update; flush clears valids only, payloads are left as-is.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v  <= '0;
            r_dm <= '0;
            r_ds <= '0;
        end else if (flush_i) begin
            r_v.vm <= 1'b0;
            r_v.vs <= 1'b0;
        end else if (w_out_ok) begin
            if (r_v.vs) begin
                r_v.vm <= 1'b1;
                r_dm   <= r_ds;
                r_v.vs <= 1'b0;
            end else if (w_take) begin
                r_v.vm <= 1'b1;
                r_dm   <= data_i;
            end else begin
                r_v.vm <= 1'b0;
            end
        end else if (w_take) begin
            r_v.vs <= 1'b1;
            r_ds   <= data_i;
        end
    end

    assign stall_o = r_v.vs;
    assign v_o     = r_v.vm;
    assign data_o  = r_dm;
    assign occ_o   = occ_of(r_v);

endmodule : skid_stage
`default_nettype wire

// File: rtl/elastic_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipeline
// Description : DEPTH-stage valid/stall pipeline built from skid stages.
//               Upstream stall is registered, so no combinational stall path
//               spans the chain. Provides synchronous flush and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       flush_i,
    elastic_pipeline_if.slave               up,
    elastic_pipeline_if.master              dn,
    output logic [$clog2(2*DEPTH+1)-1:0]    count_o
);

    localparam int CW = count_width(DEPTH);

    // Element k is the link between stage k-1 and stage k; element 0 is the
    // upstream port and element DEPTH the downstream port.
    logic             w_v     [DEPTH+1];
    logic [WIDTH-1:0] w_data  [DEPTH+1];
    logic             w_stall [DEPTH+1];
    logic [1:0]       w_occ   [DEPTH];
    logic [CW-1:0]    w_count;

    assign w_v[0]         = up.v;
    assign w_data[0]      = up.data;
    assign up.stall       = w_stall[0];
    assign dn.v           = w_v[DEPTH];
    assign dn.data        = w_data[DEPTH];
    assign w_stall[DEPTH] = dn.stall;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            skid_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .flush_i (flush_i),
                .v_i     (w_v[k]),
                .data_i  (w_data[k]),
                .stall_o (w_stall[k]),
                .v_o     (w_v[k+1]),
                .data_o  (w_data[k+1]),
                .stall_i (w_stall[k+1]),
                .occ_o   (w_occ[k])
            );
        end
    endgenerate

    // Occupancy: sum of per-stage item counts, all taken from flops.
    always_comb begin
        w_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_count = w_count + CW'(w_occ[k]);
        end
    end

    assign count_o = w_count;

endmodule : elastic_pipeline
`default_nettype wire
